// File: rtl/pipearch_read_stream_if.sv
// Bundle of the c0 read-request / read-response channel and the consumer-side
// line stream used by pipearch_read_stream.
//   c0_tx_*      : single-line read request toward CCI-P (valid + header fields)
//   c0TxAlmFull  : CCI-P c0 request back-pressure
//   c0_rx_*      : read response from CCI-P (rspValid + header + line data)
//   out_valid / out_data / out_almostfull : in-order line stream to the consumer
// master: the read streamer; slave: the environment (CCI-P + consumer).
interface pipearch_read_stream_if #(
    parameter int unsigned ADDR_W  = 42,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned MDATA_W = 16
);
    logic               c0TxAlmFull;
    logic               c0_tx_valid;
    logic [3:0]         c0_tx_req_type;
    logic [1:0]         c0_tx_vc_sel;
    logic [1:0]         c0_tx_cl_len;
    logic [ADDR_W-1:0]  c0_tx_addr;
    logic [MDATA_W-1:0] c0_tx_mdata;

    logic               c0_rx_rspValid;
    logic [3:0]         c0_rx_resp_type;
    logic [MDATA_W-1:0] c0_rx_mdata;
    logic [DATA_W-1:0]  c0_rx_data;

    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_almostfull;

    modport master (
        output c0_tx_valid, c0_tx_req_type, c0_tx_vc_sel, c0_tx_cl_len,
               c0_tx_addr, c0_tx_mdata, out_valid, out_data,
        input  c0TxAlmFull, c0_rx_rspValid, c0_rx_resp_type, c0_rx_mdata,
               c0_rx_data, out_almostfull
    );

    modport slave (
        input  c0_tx_valid, c0_tx_req_type, c0_tx_vc_sel, c0_tx_cl_len,
               c0_tx_addr, c0_tx_mdata, out_valid, out_data,
        output c0TxAlmFull, c0_rx_rspValid, c0_rx_resp_type, c0_rx_mdata,
               c0_rx_data, out_almostfull
    );
endinterface

// File: rtl/pipearch_read_stream.sv
// Read streamer: on op_start issues single-line c0 reads for a contiguous
// region (base + 0 .. base + len-1) and returns the lines to the consumer in
// strict address order. Responses may return out of order; a DEPTH-entry
// reorder buffer indexed by mdata restores order.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   op_start     : start pulse, honoured only in IDLE
//   op_done      : one-cycle completion pulse
//   regs0        : bit31 selects out_addr (1) or in_addr (0) base; [30:0] line offset
//   regs1        : [15:0] line count
//   in_addr, out_addr : region base line addresses
//   bus          : c0 request/response channel and consumer stream (master side)
module pipearch_read_stream #(
    parameter int unsigned LOG_DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    output logic        op_done,
    input  logic [31:0] regs0,
    input  logic [31:0] regs1,
    input  logic [41:0] in_addr,
    input  logic [41:0] out_addr,
    pipearch_read_stream_if.master bus
);
    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    localparam logic [3:0] REQ_RDLINE_I = 4'h0;
    localparam logic [3:0] RSP_RDLINE   = 4'h0;
    localparam logic [1:0] VC_VA        = 2'h0;
    localparam logic [1:0] CL_LEN_1     = 2'h0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [41:0]          base;
    logic [15:0]          len;
    logic [15:0]          num_req;
    logic [15:0]          num_rsp;
    logic [15:0]          num_out;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [DEPTH-1:0]     rob_valid;
    logic [511:0]         rob [DEPTH];

    logic [16:0]          in_flight;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 drain_fire;
    logic [LOG_DEPTH-1:0] rsp_slot;

    logic unused_bits;
    assign unused_bits = ^{regs1[31:16], bus.c0_rx_mdata[15:LOG_DEPTH], num_rsp};

    always_comb begin
        state_next = state;
        // Lines requested but not yet handed to the consumer; bounds ROB use.
        in_flight  = {1'b0, num_req} - {1'b0, num_out};
        req_fire   = (state == RUN) && (num_req < len) && !bus.c0TxAlmFull &&
                     (in_flight < 17'(DEPTH));
        rsp_fire   = (state == RUN) && bus.c0_rx_rspValid &&
                     (bus.c0_rx_resp_type == RSP_RDLINE);
        rsp_slot   = bus.c0_rx_mdata[LOG_DEPTH-1:0];
        drain_fire = rob_valid[rd_ptr] && !bus.out_almostfull;

        case (state)
            IDLE: begin
                if (op_start) begin
                    state_next = (regs1[15:0] == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (num_out == len) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_done            <= 1'b0;
            base               <= '0;
            len                <= '0;
            num_req            <= '0;
            num_rsp            <= '0;
            num_out            <= '0;
            rd_ptr             <= '0;
            rob_valid          <= '0;
            bus.c0_tx_valid    <= 1'b0;
            bus.c0_tx_req_type <= '0;
            bus.c0_tx_vc_sel   <= '0;
            bus.c0_tx_cl_len   <= '0;
            bus.c0_tx_addr     <= '0;
            bus.c0_tx_mdata    <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_data       <= '0;
        end else begin
            op_done         <= (state == DONE);
            bus.c0_tx_valid <= req_fire;
            bus.out_valid   <= drain_fire;

            if ((state == IDLE) && op_start) begin
                base    <= (regs0[31] ? out_addr : in_addr) + 42'(regs0[30:0]);
                len     <= regs1[15:0];
                num_req <= '0;
                num_rsp <= '0;
                num_out <= '0;
                rd_ptr  <= '0;
            end

            if (req_fire) begin
                bus.c0_tx_req_type <= REQ_RDLINE_I;
                bus.c0_tx_vc_sel   <= VC_VA;
                bus.c0_tx_cl_len   <= CL_LEN_1;
                bus.c0_tx_addr     <= base + 42'(num_req);
                bus.c0_tx_mdata    <= 16'(num_req[LOG_DEPTH-1:0]);
                num_req            <= num_req + 16'd1;
            end

            if (rsp_fire) begin
                num_rsp <= num_rsp + 16'd1;
            end

            if (drain_fire) begin
                bus.out_data <= rob[rd_ptr];
                rd_ptr       <= rd_ptr + 1'b1;
                num_out      <= num_out + 16'd1;
            end

            // A draining slot is never the target of a legal response, so
            // clear-then-set on the valid vector cannot collide.
            if (drain_fire) begin
                rob_valid[rd_ptr] <= 1'b0;
            end
            if (rsp_fire) begin
                rob_valid[rsp_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            rob[rsp_slot] <= bus.c0_rx_data;
        end
    end
endmodule

// File: tb/tb_pipearch_read_stream.sv
module tb_pipearch_read_stream;
    logic        clk;
    logic        reset;
    logic        op_start;
    logic        op_done;
    logic [31:0] regs0;
    logic [31:0] regs1;
    logic [41:0] in_addr;
    logic [41:0] out_addr;

    pipearch_read_stream_if bus ();

    pipearch_read_stream #(.LOG_DEPTH(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_start (op_start),
        .op_done  (op_done),
        .regs0    (regs0),
        .regs1    (regs1),
        .in_addr  (in_addr),
        .out_addr (out_addr),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input logic [41:0] a);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = (a[31:0] + 32'(i) * 32'h9E37_79B9) ^ {22'h0, a[41:32]};
        end
        return d;
    endfunction

    // ---------------- model state (stimulus-owned) ----------------
    logic [41:0] exp_base = '0;
    int          exp_len  = 0;
    int          op_seq   = 0;

    // knobs
    int rsp_mode  = 0;   // 0 in-order, 1 random order, 2 scripted mdata order
    int rsp_pct   = 100;
    int junk_pct  = 0;
    int alm_pct   = 0;
    int oaf_pct   = 0;
    bit alm_force = 0;
    bit oaf_force = 0;
    int script [4] = '{3, 1, 0, 2};

    // ---------------- compare process ----------------
    int cyc = 0;
    logic alm_s = 1'b0;
    logic oaf_s = 1'b0;
    int req_cnt = 0;
    int out_cnt = 0;
    int done_cyc = -1;
    int ops_done = 0;
    int seen_seq = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        alm_s <= bus.c0TxAlmFull;
        oaf_s <= bus.out_almostfull;
    end

    always @(negedge clk) begin
        if (reset) begin
            req_cnt  = 0;
            out_cnt  = 0;
            done_cyc = -1;
            seen_seq = op_seq;
        end else begin
            if (seen_seq != op_seq) begin
                seen_seq = op_seq;
                req_cnt  = 0;
                out_cnt  = 0;
                done_cyc = (exp_len == 0) ? cyc + 2 : -1;
            end
            if (bus.c0_tx_valid) begin
                check("req_legal", {alm_s, req_cnt < exp_len, (req_cnt - out_cnt) < 64}, 3'b011);
                check("req_addr", bus.c0_tx_addr, exp_base + 42'(req_cnt));
                check("req_mdata", bus.c0_tx_mdata, 16'(req_cnt % 64));
                check("req_hdr", {bus.c0_tx_req_type, bus.c0_tx_vc_sel, bus.c0_tx_cl_len}, 8'h00);
                req_cnt++;
            end
            if (bus.out_valid) begin
                check("out_legal", {oaf_s, out_cnt < exp_len, out_cnt < req_cnt}, 3'b011);
                check("out_data", bus.out_data, line_data(exp_base + 42'(out_cnt)));
                out_cnt++;
                if (out_cnt == exp_len) done_cyc = cyc + 2;
            end
            if (op_done || cyc == done_cyc) begin
                check("op_done", op_done, cyc == done_cyc);
                if (op_done) ops_done++;
            end
        end
    end

    // ---------------- responder (owns pending queue) ----------------
    typedef struct {
        logic [41:0] addr;
        logic [15:0] mdata;
    } req_t;
    req_t pend[$];
    int   rsp_sent = 0;

    initial begin
        int sp;
        int rseq;
        int idx;
        sp   = 0;
        rseq = 0;
        bus.c0_rx_rspValid  = 1'b0;
        bus.c0_rx_resp_type = 4'h0;
        bus.c0_rx_mdata     = '0;
        bus.c0_rx_data      = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend.delete();
                sp = 0;
            end else if (bus.c0_tx_valid) begin
                pend.push_back('{bus.c0_tx_addr, bus.c0_tx_mdata});
            end
            if (rseq != op_seq) begin
                rseq = op_seq;
                sp   = 0;
            end
            @(posedge clk);
            #1;
            bus.c0_rx_rspValid  = 1'b0;
            bus.c0_rx_resp_type = 4'h0;
            bus.c0_rx_mdata     = '0;
            bus.c0_rx_data      = '0;
            idx = -1;
            if (!reset && pend.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
                if (rsp_mode == 0) idx = 0;
                else if (rsp_mode == 1) idx = $urandom_range(0, pend.size() - 1);
                else if (sp < 4) begin
                    foreach (pend[j]) if (pend[j].mdata == 16'(script[sp])) idx = j;
                    if (idx >= 0) sp++;
                end
            end
            if (idx >= 0) begin
                bus.c0_rx_rspValid = 1'b1;
                bus.c0_rx_mdata    = pend[idx].mdata;
                bus.c0_rx_data     = line_data(pend[idx].addr);
                pend.delete(idx);
                rsp_sent++;
            end else if ($urandom_range(0, 99) < junk_pct) begin
                bus.c0_rx_rspValid  = 1'b1;
                bus.c0_rx_resp_type = 4'h1;
                bus.c0_rx_mdata     = 16'($urandom);
                bus.c0_rx_data      = {16{$urandom}};
            end
        end
    end

    // ---------------- throttles ----------------
    initial begin
        bus.c0TxAlmFull    = 1'b0;
        bus.out_almostfull = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.c0TxAlmFull    = alm_force || ($urandom_range(0, 99) < alm_pct);
            bus.out_almostfull = oaf_force || ($urandom_range(0, 99) < oaf_pct);
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input logic [31:0] r0, input logic [31:0] r1);
        @(posedge clk);
        #1;
        regs0    = r0;
        regs1    = r1;
        exp_base = (r0[31] ? out_addr : in_addr) + 42'(r0[30:0]);
        exp_len  = int'(r1[15:0]);
        op_seq++;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s;
        bit seen;
        s    = ops_done;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (ops_done != s) seen = 1;
        end
        check("op_complete", seen, 1'b1);
    endtask

    task automatic wait_tx(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.c0_tx_valid) seen = 1;
        end
        check("req_seen", seen, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        op_start = 1'b0;
        regs0    = '0;
        regs1    = '0;
        in_addr  = 42'h000_0000_1000;
        out_addr = 42'h200_0000_0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_valid", bus.c0_tx_valid, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_op_done", op_done, 1'b0);

        // in-order, no back-pressure
        start_op(32'h0000_0010, 32'd4);
        wait_tx(20);
        check("t1_addr0", bus.c0_tx_addr, 42'h000_0000_1010);
        check("t1_mdata0", bus.c0_tx_mdata, 16'd0);
        wait_done(200);
        check("t1_lines", out_cnt, 4);

        // scripted response order 3,1,0,2
        rsp_mode = 2;
        begin
            int s0;
            bit hit;
            s0  = rsp_sent;
            hit = 0;
            start_op(32'h0000_0100, 32'd4);
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (rsp_sent - s0 >= 2) hit = 1;
            end
            check("t2_no_early_out", {hit, 16'(out_cnt)}, {1'b1, 16'd0});
        end
        wait_done(200);
        check("t2_lines", out_cnt, 4);
        rsp_mode = 0;

        // consumer stalled: ROB fills to 64 outstanding
        oaf_force = 1;
        start_op(32'h0000_0200, 32'd100);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("t3_req_cap", req_cnt, 64);
        check("t3_no_out", out_cnt, 0);
        oaf_force = 0;
        wait_done(3000);
        check("t3_lines", out_cnt, 100);

        // request back-pressure then junk responses
        alm_force = 1;
        start_op(32'h0000_0300, 32'd8);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_no_req", req_cnt, 0);
        alm_force = 0;
        junk_pct  = 50;
        wait_done(500);
        check("t4_lines", out_cnt, 8);
        junk_pct = 0;

        // out_addr base, len 0, op_start during RUN
        start_op(32'h8000_0005, 32'd1);
        wait_tx(20);
        check("t5_addr", bus.c0_tx_addr, 42'h200_0000_0005);
        wait_done(200);
        start_op(32'h0000_0000, 32'd0);
        wait_done(20);
        check("t5_len0_traffic", {16'(req_cnt), 16'(out_cnt)}, 32'd0);
        start_op(32'h0000_0020, 32'd20);
        wait_tx(20);
        @(posedge clk);
        #1;
        regs0    = 32'h0000_0007;
        regs1    = 32'd5;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        wait_done(1000);
        check("t5_restart_ignored", out_cnt, 20);

        // randomized operations
        for (int k = 0; k < 5; k++) begin
            in_addr  = 42'({$urandom, $urandom});
            out_addr = 42'({$urandom, $urandom});
            rsp_mode = $urandom_range(0, 1);
            rsp_pct  = $urandom_range(30, 100);
            alm_pct  = $urandom_range(0, 40);
            oaf_pct  = $urandom_range(0, 50);
            junk_pct = $urandom_range(0, 20);
            start_op({1'($urandom_range(0, 1)), 31'($urandom)}, 32'($urandom_range(1, 150)));
            wait_done(150 * 40 + 500);
        end
        rsp_mode = 0;
        rsp_pct  = 100;
        alm_pct  = 0;
        oaf_pct  = 0;
        junk_pct = 0;

        // reset mid-operation
        start_op(32'h0000_0040, 32'd6);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (out_cnt >= 2) hit = 1;
            end
            check("t6_two_out", hit, 1'b1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", {bus.c0_tx_valid, bus.out_valid, op_done}, 3'b000);
        check("t6_rst_data", bus.out_data, 512'd0);
        check("t6_rst_addr", bus.c0_tx_addr, 42'd0);
        start_op(32'h0000_0050, 32'd3);
        wait_done(200);
        check("t6_lines", out_cnt, 3);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipearch_read_stream.md
Name: pipearch_read_stream

Overview:
- Upstream feeder for the writeback stage: on op_start, issues CCI-P c0 single-line reads for a contiguous region and returns the lines to the consumer in strict address order.
- Read responses can arrive out of order on eVC_VA, so a DEPTH-entry reorder buffer indexed by mdata restores order.
- Throttled by c0TxAlmFull (request side) and out_almostfull (consumer side).

Parameters:
- LOG_DEPTH, 6, log2 of the number of reorder-buffer entries (DEPTH = 64); also the maximum number of lines outstanding plus buffered.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op_start  in  1  one-cycle start pulse; honoured only in IDLE
- op_done  out  1  one-cycle completion pulse
- regs0  in  32  line offset; bit31=0 selects in_addr base, bit31=1 selects out_addr base; offset = regs0[30:0]
- regs1  in  32  line count; only [15:0] used
- in_addr  in  t_ccip_clAddr  input region base
- out_addr  in  t_ccip_clAddr  output region base
- out_valid  out  1  line valid to consumer
- out_data  out  512  line data
- out_almostfull  in  1  consumer back-pressure
- c0TxAlmFull  in  1  CCI-P c0 request back-pressure
- cp2af_sRx_c0  in  t_if_ccip_c0_Rx  read responses
- af2cp_sTx_c0  out  t_if_ccip_c0_Tx  read requests

Behaviour:
- Reset: state IDLE; op_done=0; out_valid=0; af2cp_sTx_c0.valid=0; num_req, num_rsp, num_out, rd_ptr=0; all ROB valid bits=0.
- IDLE, op_start=1:
  - Latch base = (regs0[31] ? out_addr : in_addr) + regs0[30:0], zero-extended.
  - Latch len = regs1[15:0] and clear all counters.
  - Next state is DONE if len==0, else RUN.
- op_start outside IDLE: ignored.
- RUN, request side: issue a request when all of the following hold:
  - num_req < len
  - !c0TxAlmFull
  - (num_req - num_out) < DEPTH, using 17-bit unsigned difference
- Request header, registered one cycle:
  - req_type=eREQ_RDLINE_I, vc_sel=eVC_VA, cl_len=eCL_LEN_1
  - address = base + num_req
  - mdata = num_req[LOG_DEPTH-1:0], upper mdata bits 0
  - num_req increments.
- af2cp_sTx_c0.valid defaults to 0 every cycle; at most one request per cycle.
- Response side:
  - Accepted when cp2af_sRx_c0.rspValid=1 and hdr.resp_type==eRSP_RDLINE and state==RUN: write data to rob[mdata[LOG_DEPTH-1:0]], set valid[mdata], increment num_rsp.
  - Other response types, and any response outside RUN, are dropped.
- Drain side:
  - If valid[rd_ptr] && !out_almostfull: next cycle out_valid=1 and out_data=rob[rd_ptr]; clear valid[rd_ptr]; increment rd_ptr (wraps mod DEPTH) and num_out.
  - Otherwise out_valid=0. At most one line per cycle.
- Simultaneous events:
  - A response write and a drain of different slots in the same cycle are both performed.
  - A freed slot may be re-requested no earlier than the cycle after its drain; the occupancy check uses registered counts.
- Ordering: out_data sequence equals address order base, base+1, …, base+len-1, regardless of response order.
- Completion: when num_out reaches len, next state is DONE.
- DONE: op_done<=1 (high the cycle after DONE is entered, for exactly one cycle); next state IDLE.
- len==0: op_start at cycle T -> DONE at T+1 -> op_done=1 at T+2; no requests and no out_valid.
- Reset mid-operation: every register returns to its reset value on the next edge. Software must not reset with reads outstanding; late responses arriving in IDLE are dropped.
- Widths: counters 16-bit, len max 65535; address addition is t_ccip_clAddr-wide modulo 2^42.

Test Plan:
- regs0=0x10, regs1=4, in-order responses, no back-pressure -> 4 requests to in_addr+0x10..0x13 with mdata 0..3; out_data in address order; op_done pulse once, 2 cycles after the 4th out_valid.
- regs1=4, responses returned as mdata 3,1,0,2 -> out_valid only after mdata 0 arrives; output order is line0, line1, line2, line3; no duplicates.
- regs1=100, consumer holds out_almostfull=1 throughout -> exactly 64 requests issued, then none; deasserting almostfull drains lines in order and requesting resumes; total 100 lines out.
- regs1=8, c0TxAlmFull=1 for 10 cycles after start -> no requests while high; all 8 issued afterwards; responses with resp_type≠eRSP_RDLINE injected mid-run are ignored.
- regs0=0x80000005, regs1=1 -> single request to out_addr+5; regs1=0 -> op_done at T+2, no c0 traffic; op_start during RUN has no effect.
- Reset asserted after 2 of 6 lines have been output -> next cycle all outputs are 0 and state is IDLE; a following op_start with regs1=3 completes normally.
